execution_stage_m: RTL and testbench

Parametrised execute stage for the pipelined core: single-cycle integer ALU, RV32M-style multiply/divide on a shared iterative engine, operand forwarding from MEM and WB, and a registered EX/MEM output with a valid/ready handshake. It sits between decode (register file already read) and the data-memory stage. It is the first execute stage that can stall the front end, through `in_ready`, and be flushed by branch resolution.

---
 rtl/execution_stage_m.sv | 213 +++++++++++++++++++++
 tb/tb_execution_stage_m.sv | 293 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/execution_stage_m.sv
// Execute stage: single-cycle integer ALU, iterative multiply/divide engine,
// MEM/WB operand forwarding and a registered EX/MEM output with valid/ready.
module execution_stage_m #(
  parameter int XLEN   = 32,
  parameter int UNROLL = 1
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [4:0]      in_op,
  input  logic [4:0]      in_rs1,
  input  logic [4:0]      in_rs2,
  input  logic [4:0]      in_rd,
  input  logic [XLEN-1:0] in_rdata1,
  input  logic [XLEN-1:0] in_rdata2,
  input  logic [XLEN-1:0] in_imm,
  input  logic            in_use_imm,
  input  logic            fwd_mem_we,
  input  logic [4:0]      fwd_mem_rd,
  input  logic [XLEN-1:0] fwd_mem_data,
  input  logic            fwd_wb_we,
  input  logic [4:0]      fwd_wb_rd,
  input  logic [XLEN-1:0] fwd_wb_data,
  input  logic            flush,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [4:0]      out_rd,
  output logic [XLEN-1:0] out_result,
  output logic            busy
);

  localparam int ITERS = XLEN / UNROLL;
  localparam int CW    = $clog2(ITERS + 1);
  localparam int SW    = $clog2(XLEN);

  typedef enum logic [1:0] {IDLE, ITER, DONE} state_e;

  state_e            state_q, state_d;
  logic [CW-1:0]     cnt_q;
  logic [2*XLEN-1:0] acc_q, accStep;
  logic [XLEN-1:0]   operandB_q;
  logic [2:0]        mop_q;
  logic [4:0]        rd_q;
  logic              neg_q, remNeg_q;
  logic              outValid_q;
  logic [4:0]        outRd_q;
  logic [XLEN-1:0]   outResult_q;

  logic [XLEN-1:0]   opA, rs2Val, opB, aluRes;
  logic              isMulDiv, accept, loadDone;
  logic              signAEn, signBEn, aNeg, bNeg;
  logic [XLEN-1:0]   aMag, bMag;
  logic [2*XLEN:0]   mt;
  logic [XLEN:0]     dr;
  logic [XLEN-1:0]   rem, quo;
  logic [2*XLEN-1:0] prodFix;
  logic [XLEN-1:0]   quoFix, remFix, mResult;

  // The output slot may refill in the same cycle it is consumed
  assign isMulDiv  = (in_op[4:3] == 2'b10);
  assign in_ready  = !reset && !flush && (state_q == IDLE) && (!outValid_q || out_ready);
  assign accept    = in_valid && in_ready;
  assign loadDone  = (state_q == DONE) && (!outValid_q || out_ready);
  assign busy      = (state_q != IDLE);
  assign out_valid = outValid_q;
  assign out_rd    = outRd_q;
  assign out_result = outResult_q;

  // Operand selection: MEM bypass beats WB bypass, x0 never forwards
  always_comb begin
    opA = in_rdata1;
    if (in_rs1 != 5'd0 && fwd_mem_we && fwd_mem_rd == in_rs1) opA = fwd_mem_data;
    else if (in_rs1 != 5'd0 && fwd_wb_we && fwd_wb_rd == in_rs1) opA = fwd_wb_data;
    rs2Val = in_rdata2;
    if (in_rs2 != 5'd0 && fwd_mem_we && fwd_mem_rd == in_rs2) rs2Val = fwd_mem_data;
    else if (in_rs2 != 5'd0 && fwd_wb_we && fwd_wb_rd == in_rs2) rs2Val = fwd_wb_data;
    opB = in_use_imm ? in_imm : rs2Val;
  end

  // Single-cycle ALU; unknown codes produce zero
  always_comb begin
    aluRes = '0;
    case (in_op)
      5'd0:    aluRes = opA + opB;
      5'd1:    aluRes = opA - opB;
      5'd2:    aluRes = opA & opB;
      5'd3:    aluRes = opA | opB;
      5'd4:    aluRes = opA ^ opB;
      5'd5:    aluRes = opA << opB[SW-1:0];
      5'd6:    aluRes = opA >> opB[SW-1:0];
      5'd7:    aluRes = $signed(opA) >>> opB[SW-1:0];
      5'd8:    aluRes = {{(XLEN-1){1'b0}}, ($signed(opA) < $signed(opB))};
      5'd9:    aluRes = {{(XLEN-1){1'b0}}, (opA < opB)};
      default: aluRes = '0;
    endcase
  end

  // Reduce multiply/divide operands to magnitudes plus sign flags
  always_comb begin
    if (in_op[2]) begin
      signAEn = !in_op[0];
      signBEn = !in_op[0];
    end else begin
      signAEn = (in_op[1:0] != 2'b11);
      signBEn = !in_op[1];
    end
    aNeg = signAEn && opA[XLEN-1];
    bNeg = signBEn && opB[XLEN-1];
    aMag = aNeg ? ('0 - opA) : opA;
    bMag = bNeg ? ('0 - opB) : opB;
  end

  // One iteration: UNROLL shift-add product bits or restoring quotient bits
  always_comb begin
    mt      = {1'b0, acc_q};
    dr      = '0;
    rem     = acc_q[2*XLEN-1:XLEN];
    quo     = acc_q[XLEN-1:0];
    accStep = acc_q;
    if (mop_q[2]) begin
      for (int u = 0; u < UNROLL; u++) begin
        dr  = {rem, quo[XLEN-1]};
        quo = {quo[XLEN-2:0], 1'b0};
        if (dr >= {1'b0, operandB_q}) begin
          dr     = dr - {1'b0, operandB_q};
          quo[0] = 1'b1;
        end
        rem = dr[XLEN-1:0];
      end
      accStep = {rem, quo};
    end else begin
      for (int u = 0; u < UNROLL; u++) begin
        if (mt[0]) mt[2*XLEN:XLEN] = {1'b0, mt[2*XLEN-1:XLEN]} + {1'b0, operandB_q};
        mt = mt >> 1;
      end
      accStep = mt[2*XLEN-1:0];
    end
  end

  // Apply signs once iteration is finished and pick the requested half
  always_comb begin
    prodFix = neg_q ? ('0 - acc_q) : acc_q;
    quoFix  = neg_q ? ('0 - acc_q[XLEN-1:0]) : acc_q[XLEN-1:0];
    remFix  = remNeg_q ? ('0 - acc_q[2*XLEN-1:XLEN]) : acc_q[2*XLEN-1:XLEN];
    if (mop_q[2]) mResult = mop_q[1] ? remFix : quoFix;
    else          mResult = (mop_q[1:0] == 2'b00) ? prodFix[XLEN-1:0] : prodFix[2*XLEN-1:XLEN];
  end

  // Next-state logic; flush always returns to IDLE
  always_comb begin
    state_d = state_q;
    if (flush) begin
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE:    if (accept && isMulDiv) state_d = ITER;
        ITER:    if (cnt_q == CW'(1)) state_d = DONE;
        DONE:    if (loadDone) state_d = IDLE;
        default: state_d = IDLE;
      endcase
    end
  end

  // State register
  always_ff @(posedge clk) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  // Engine registers and the EX/MEM output register
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q       <= '0;
      acc_q       <= '0;
      operandB_q  <= '0;
      mop_q       <= '0;
      rd_q        <= '0;
      neg_q       <= 1'b0;
      remNeg_q    <= 1'b0;
      outValid_q  <= 1'b0;
      outRd_q     <= '0;
      outResult_q <= '0;
    end else begin
      if (accept && isMulDiv) begin
        cnt_q      <= CW'(ITERS);
        acc_q      <= {{XLEN{1'b0}}, aMag};
        operandB_q <= bMag;
        mop_q      <= in_op[2:0];
        rd_q       <= in_rd;
        neg_q      <= (aNeg ^ bNeg) && !(in_op[2] && opB == '0);
        remNeg_q   <= aNeg;
      end else if (state_q == ITER) begin
        cnt_q <= cnt_q - CW'(1);
        acc_q <= accStep;
      end
      if (flush) begin
        outValid_q <= 1'b0;
      end else if (accept && !isMulDiv) begin
        outValid_q  <= 1'b1;
        outRd_q     <= in_rd;
        outResult_q <= aluRes;
      end else if (loadDone) begin
        outValid_q  <= 1'b1;
        outRd_q     <= rd_q;
        outResult_q <= mResult;
      end else if (out_ready) begin
        outValid_q <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_execution_stage_m.sv
// Directed bench for execution_stage_m with a result scoreboard; a second
// instance runs with UNROLL=4 to cover the shortened iteration latency.
module tb_execution_stage_m;

  logic        clk = 1'b0;
  logic        reset, in_valid, in_valid4, flush, flush4, in_use_imm;
  logic        fwd_mem_we, fwd_wb_we, out_ready;
  logic [4:0]  in_op, in_rs1, in_rs2, in_rd, fwd_mem_rd, fwd_wb_rd;
  logic [31:0] in_rdata1, in_rdata2, in_imm, fwd_mem_data, fwd_wb_data;
  logic        in_ready, out_valid, busy;
  logic [4:0]  out_rd;
  logic [31:0] out_result;
  logic        in_ready4, out_valid4, busy4;
  logic [4:0]  out_rd4;
  logic [31:0] out_result4;

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int accCyc = 0;
  logic [36:0] sb[$];

  execution_stage_m #(.XLEN(32), .UNROLL(1)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .in_op(in_op), .in_rs1(in_rs1), .in_rs2(in_rs2), .in_rd(in_rd),
    .in_rdata1(in_rdata1), .in_rdata2(in_rdata2), .in_imm(in_imm), .in_use_imm(in_use_imm),
    .fwd_mem_we(fwd_mem_we), .fwd_mem_rd(fwd_mem_rd), .fwd_mem_data(fwd_mem_data),
    .fwd_wb_we(fwd_wb_we), .fwd_wb_rd(fwd_wb_rd), .fwd_wb_data(fwd_wb_data),
    .flush(flush), .out_valid(out_valid), .out_ready(out_ready), .out_rd(out_rd),
    .out_result(out_result), .busy(busy)
  );

  execution_stage_m #(.XLEN(32), .UNROLL(4)) dut4 (
    .clk(clk), .reset(reset), .in_valid(in_valid4), .in_ready(in_ready4),
    .in_op(in_op), .in_rs1(in_rs1), .in_rs2(in_rs2), .in_rd(in_rd),
    .in_rdata1(in_rdata1), .in_rdata2(in_rdata2), .in_imm(in_imm), .in_use_imm(in_use_imm),
    .fwd_mem_we(fwd_mem_we), .fwd_mem_rd(fwd_mem_rd), .fwd_mem_data(fwd_mem_data),
    .fwd_wb_we(fwd_wb_we), .fwd_wb_rd(fwd_wb_rd), .fwd_wb_data(fwd_wb_data),
    .flush(flush4), .out_valid(out_valid4), .out_ready(out_ready), .out_rd(out_rd4),
    .out_result(out_result4), .busy(busy4)
  );

  // Free-running clock and cycle counter
  always #5 clk = ~clk;

  // Cycle counter used for latency measurement
  always @(posedge clk) cyc <= cyc + 1;

  // Watchdog so the run always terminates
  initial begin
    #500000;
    $display("[TB] FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  // Reference behaviour of every op on already-forwarded operands
  function automatic logic [31:0] refModel(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b);
    longint sa, sb2;
    longint unsigned ua, ub;
    logic [63:0] p;
    sa  = longint'($signed(a));
    sb2 = longint'($signed(b));
    ua  = {32'd0, a};
    ub  = {32'd0, b};
    case (op)
      5'd0:  return a + b;
      5'd1:  return a - b;
      5'd2:  return a & b;
      5'd3:  return a | b;
      5'd4:  return a ^ b;
      5'd5:  return a << b[4:0];
      5'd6:  return a >> b[4:0];
      5'd7:  return $signed(a) >>> b[4:0];
      5'd8:  return {31'd0, $signed(a) < $signed(b)};
      5'd9:  return {31'd0, a < b};
      5'd16: begin p = sa * sb2; return p[31:0]; end
      5'd17: begin p = sa * sb2; return p[63:32]; end
      5'd18: begin p = sa * longint'(ub); return p[63:32]; end
      5'd19: begin p = ua * ub; return p[63:32]; end
      5'd20: begin
        if (b == 32'd0) return 32'hFFFFFFFF;
        if (a == 32'h80000000 && b == 32'hFFFFFFFF) return 32'h80000000;
        return 32'(sa / sb2);
      end
      5'd21: return (b == 32'd0) ? 32'hFFFFFFFF : a / b;
      5'd22: begin
        if (b == 32'd0) return a;
        if (a == 32'h80000000 && b == 32'hFFFFFFFF) return 32'd0;
        return 32'(sa % sb2);
      end
      5'd23: return (b == 32'd0) ? a : a % b;
      default: return 32'd0;
    endcase
  endfunction

  task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Present one instruction, wait (bounded) for acceptance, queue its result
  task automatic applyStimulus(input bit u4, input logic [4:0] op, input logic [4:0] rs1,
                               input logic [4:0] rs2, input logic [4:0] rd, input logic [31:0] d1,
                               input logic [31:0] d2, input logic [31:0] imm, input bit useImm,
                               input logic [31:0] expRes);
    bit accepted = 0;
    in_op = op; in_rs1 = rs1; in_rs2 = rs2; in_rd = rd;
    in_rdata1 = d1; in_rdata2 = d2; in_imm = imm; in_use_imm = useImm;
    if (u4) in_valid4 = 1'b1; else in_valid = 1'b1;
    for (int i = 0; i < 60; i++) begin
      if ((u4 ? in_ready4 : in_ready) === 1'b1) begin
        accCyc = cyc;
        accepted = 1;
        break;
      end
      @(negedge clk);
    end
    if (!accepted) checkOutput("accept_timeout", 64'(accepted), 64'd1);
    @(negedge clk);
    in_valid = 1'b0;
    in_valid4 = 1'b0;
    sb.push_back({rd, expRes});
  endtask

  // Wait (bounded) for out_valid, then pop and compare; stays on that cycle
  task automatic waitResult(input bit u4, input string tag, input int expLat);
    logic [36:0] e;
    bit seen = 0;
    for (int i = 0; i < 100; i++) begin
      if ((u4 ? out_valid4 : out_valid) === 1'b1) begin
        seen = 1;
        break;
      end
      @(negedge clk);
    end
    checkOutput({tag, "_valid"}, 64'(seen), 64'd1);
    if (seen && sb.size() > 0) begin
      e = sb.pop_front();
      checkOutput({tag, "_result"}, 64'(u4 ? out_result4 : out_result), 64'(e[31:0]));
      checkOutput({tag, "_rd"}, 64'(u4 ? out_rd4 : out_rd), 64'(e[36:32]));
      if (expLat >= 0) checkOutput({tag, "_latency"}, 64'(cyc - accCyc), 64'(expLat));
    end
  endtask

  task automatic doOp(input bit u4, input logic [4:0] op, input logic [31:0] d1, input logic [31:0] d2,
                      input logic [31:0] expRes, input string tag, input int expLat);
    applyStimulus(u4, op, 5'd1, 5'd2, 5'd9, d1, d2, 32'd0, 1'b0, expRes);
    waitResult(u4, tag, expLat);
    @(negedge clk);
  endtask

  logic [4:0]  b2bOps [4] = '{5'd1, 5'd7, 5'd9, 5'd4};
  logic [31:0] ra, rb;
  int emitted;

  initial begin
    reset = 1'b1; in_valid = 0; in_valid4 = 0; flush = 0; flush4 = 0; in_use_imm = 0;
    fwd_mem_we = 0; fwd_wb_we = 0; out_ready = 1'b1;
    in_op = 0; in_rs1 = 0; in_rs2 = 0; in_rd = 0; fwd_mem_rd = 0; fwd_wb_rd = 0;
    in_rdata1 = 0; in_rdata2 = 0; in_imm = 0; fwd_mem_data = 0; fwd_wb_data = 0;
    @(negedge clk);
    @(negedge clk);
    checkOutput("rst_in_ready", 64'(in_ready), 64'd0);
    checkOutput("rst_in_ready4", 64'(in_ready4), 64'd0);
    checkOutput("rst_out_valid", 64'(out_valid), 64'd0);
    checkOutput("rst_busy", 64'(busy), 64'd0);
    checkOutput("rst_out_result", 64'(out_result), 64'd0);
    checkOutput("rst_out_rd", 64'(out_rd), 64'd0);
    reset = 1'b0;
    @(negedge clk);

    applyStimulus(0, 5'd0, 5'd1, 5'd2, 5'd4, 32'd5, 32'd7, 32'd0, 1'b0, 32'd12);
    waitResult(0, "add", 1);
    @(negedge clk);

    // Back-to-back single-cycle ops with out_ready held high
    for (int k = 0; k < 4; k++) begin
      ra = $urandom; rb = $urandom;
      in_op = b2bOps[k]; in_rs1 = 5'd1; in_rs2 = 5'd2; in_rd = 5'(8 + k);
      in_rdata1 = ra; in_use_imm = k[0];
      in_imm = rb; in_rdata2 = k[0] ? (rb ^ 32'h5A5A5A5A) : rb;
      in_valid = 1'b1;
      if (k > 0) waitResult(0, "b2b", -1);
      checkOutput("b2b_ready", 64'(in_ready), 64'd1);
      sb.push_back({5'(8 + k), refModel(b2bOps[k], ra, rb)});
      @(negedge clk);
    end
    in_valid = 1'b0;
    waitResult(0, "b2b_last", -1);
    @(negedge clk);

    // Forwarding priority and x0 exclusion
    fwd_mem_we = 1; fwd_mem_rd = 5'd3; fwd_mem_data = 32'd100;
    fwd_wb_we = 1; fwd_wb_rd = 5'd3; fwd_wb_data = 32'd200;
    applyStimulus(0, 5'd0, 5'd3, 5'd0, 5'd5, 32'd1, 32'd0, 32'd0, 1'b1, 32'd100);
    waitResult(0, "fwd_mem", 1);
    @(negedge clk);
    fwd_mem_rd = 5'd7; fwd_wb_rd = 5'd6; fwd_wb_data = 32'd50;
    applyStimulus(0, 5'd0, 5'd1, 5'd6, 5'd6, 32'd20, 32'd999, 32'd0, 1'b0, 32'd70);
    waitResult(0, "fwd_wb", 1);
    @(negedge clk);
    fwd_mem_rd = 5'd0; fwd_mem_data = 32'd9; fwd_wb_rd = 5'd0;
    applyStimulus(0, 5'd0, 5'd0, 5'd0, 5'd7, 32'd11, 32'd0, 32'd0, 1'b1, 32'd11);
    waitResult(0, "fwd_x0", 1);
    @(negedge clk);
    fwd_mem_we = 0; fwd_wb_we = 0;

    // Multiply
    doOp(0, 5'd16, 32'hFFFFFFFD, 32'd7, 32'hFFFFFFEB, "mul", 34);
    doOp(0, 5'd17, 32'hFFFFFFFD, 32'd7, 32'hFFFFFFFF, "mulh", 34);
    doOp(0, 5'd19, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, "mulhu", 34);
    doOp(0, 5'd18, 32'hFFFFFFFD, 32'h80000000, refModel(5'd18, 32'hFFFFFFFD, 32'h80000000), "mulhsu", 34);
    ra = $urandom; rb = $urandom;
    doOp(0, 5'd17, ra, rb, refModel(5'd17, ra, rb), "mulh_rand", 34);

    // Divide corners
    doOp(0, 5'd20, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFD, "div_neg", 34);
    doOp(0, 5'd22, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFF, "rem_neg", 34);
    doOp(0, 5'd21, 32'd123, 32'd0, 32'hFFFFFFFF, "divu_zero", 34);
    doOp(0, 5'd22, 32'hFFFFFFFB, 32'd0, 32'hFFFFFFFB, "rem_zero", 34);
    doOp(0, 5'd20, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, "div_ovf", 34);
    doOp(0, 5'd22, 32'h80000000, 32'hFFFFFFFF, 32'd0, "rem_ovf", 34);
    ra = $urandom; rb = $urandom_range(1, 1000);
    doOp(0, 5'd23, ra, rb, refModel(5'd23, ra, rb), "remu_rand", 34);

    // Backpressure while a divide finishes
    applyStimulus(0, 5'd21, 5'd1, 5'd2, 5'd12, 32'd100, 32'd7, 32'd0, 1'b0, 32'd14);
    out_ready = 1'b0;
    waitResult(0, "bp_div", 34);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checkOutput("bp_hold_valid", 64'(out_valid), 64'd1);
      checkOutput("bp_hold_result", 64'(out_result), 64'd14);
      checkOutput("bp_in_ready", 64'(in_ready), 64'd0);
    end
    in_op = 5'd0; in_rdata1 = 32'd1; in_rdata2 = 32'd2; in_use_imm = 0; in_rd = 5'd13; in_valid = 1'b1;
    @(negedge clk);
    checkOutput("bp_no_accept", 64'(out_result), 64'd14);
    out_ready = 1'b1;
    applyStimulus(0, 5'd0, 5'd1, 5'd2, 5'd13, 32'd1, 32'd2, 32'd0, 1'b0, 32'd3);
    waitResult(0, "bp_add", 1);
    @(negedge clk);

    // Flush in the 10th iteration cycle
    applyStimulus(0, 5'd20, 5'd1, 5'd2, 5'd14, 32'd1000, 32'd3, 32'd0, 1'b0, 32'd333);
    repeat (9) @(negedge clk);
    flush = 1'b1;
    checkOutput("flush_in_ready", 64'(in_ready), 64'd0);
    @(negedge clk);
    flush = 1'b0;
    checkOutput("flush_busy", 64'(busy), 64'd0);
    checkOutput("flush_out_valid", 64'(out_valid), 64'd0);
    void'(sb.pop_back());
    doOp(0, 5'd0, 32'd40, 32'd2, 32'd42, "post_flush_add", 1);

    // Reset mid-iteration emits nothing
    applyStimulus(0, 5'd16, 5'd1, 5'd2, 5'd15, 32'd6, 32'd7, 32'd0, 1'b0, 32'd42);
    repeat (5) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    checkOutput("midrst_busy", 64'(busy), 64'd0);
    void'(sb.pop_back());
    emitted = 0;
    for (int i = 0; i < 40; i++) begin
      if (out_valid === 1'b1) emitted++;
      @(negedge clk);
    end
    checkOutput("midrst_no_emit", 64'(emitted), 64'd0);

    // UNROLL=4 instance
    doOp(1, 5'd16, 32'hFFFFFFFD, 32'd7, 32'hFFFFFFEB, "u4_mul", 10);
    doOp(1, 5'd20, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFD, "u4_div", 10);
    ra = $urandom; rb = $urandom;
    doOp(1, 5'd19, ra, rb, refModel(5'd19, ra, rb), "u4_mulhu", 10);
    applyStimulus(1, 5'd21, 5'd1, 5'd2, 5'd16, 32'd77, 32'd5, 32'd0, 1'b0, 32'd15);
    repeat (3) @(negedge clk);
    flush4 = 1'b1;
    @(negedge clk);
    flush4 = 1'b0;
    checkOutput("u4_flush_busy", 64'(busy4), 64'd0);
    checkOutput("u4_flush_out_valid", 64'(out_valid4), 64'd0);
    void'(sb.pop_back());
    doOp(1, 5'd0, 32'd8, 32'd9, 32'd17, "u4_post_flush_add", 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
